ssd_scan_driver: RTL and testbench

//  Downstream display stage for the processor board top. Takes a 16-bit hex value, captures it

---
 rtl/ssd_scan_driver_if.sv | 10 +
 rtl/ssd_scan_driver.sv | 121 ++++++++++++
 tb/tb_ssd_scan_driver.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ssd_scan_driver_if.sv
// rtl/ssd_scan_driver_if.sv - value/load/ack handshake bundle for the 7-seg scan driver
interface ssd_scan_driver_if;
    logic [15:0] value;
    logic        load;
    logic        ack;
    logic        frame_tick;

    modport master (output value, load, input ack, frame_tick);
    modport slave  (input value, load, output ack, frame_tick);
endinterface

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - tear-free 4-digit 7-seg scan driver with guard, blanking and load/ack
module ssd_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4,
    parameter int BLANK_LZ    = 1
) (
    input  logic                real_clk,
    input  logic                reset,
    ssd_scan_driver_if.slave    bus,
    output logic [3:0]          A,
    output logic [6:0]          C
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

    typedef enum logic {S_INIT, S_SCAN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [15:0]   shown, shown_nxt;
    logic [15:0]   pending_val;
    logic          pending;
    logic          tick, boundary, capture;
    logic          ack_r, frame_tick_r;
    logic [3:0]    a_nxt;
    logic [6:0]    c_nxt;
    logic [3:0]    nib;
    logic          blank;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b0000001;
            4'h1: seg7 = 7'b1001111;
            4'h2: seg7 = 7'b0010010;
            4'h3: seg7 = 7'b0000110;
            4'h4: seg7 = 7'b1001100;
            4'h5: seg7 = 7'b0100100;
            4'h6: seg7 = 7'b0100000;
            4'h7: seg7 = 7'b0001111;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0000100;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b1100000;
            4'hC: seg7 = 7'b0110001;
            4'hD: seg7 = 7'b1000010;
            4'hE: seg7 = 7'b0110000;
            default: seg7 = 7'b0111000;
        endcase
    endfunction

    always_ff @(posedge real_clk) begin
        if (reset) begin
            state        <= S_INIT;
            cnt          <= '0;
            idx          <= 2'd0;
            shown        <= 16'h0000;
            pending      <= 1'b0;
            pending_val  <= 16'h0000;
            ack_r        <= 1'b0;
            frame_tick_r <= 1'b0;
            A            <= 4'b1111;
            C            <= 7'h7F;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            idx          <= idx_nxt;
            shown        <= shown_nxt;
            ack_r        <= capture;
            frame_tick_r <= boundary;
            A            <= a_nxt;
            C            <= c_nxt;
            // A boundary always consumes or bypasses the pending slot.
            if (boundary) begin
                pending <= 1'b0;
            end else if (bus.load) begin
                pending     <= 1'b1;
                pending_val <= bus.value;
            end
        end
    end

    always_comb begin
        tick      = (cnt == LAST);
        boundary  = tick && (idx == 2'd0);
        capture   = boundary && (bus.load || pending);
        cnt_nxt   = tick ? '0 : cnt + CW'(1);
        // Ring order 0->3->2->1->0 is a plain mod-4 decrement.
        idx_nxt   = tick ? idx - 2'd1 : idx;
        state_nxt = (state == S_INIT && tick) ? S_SCAN : state;
        shown_nxt = shown;
        if (boundary) begin
            if (bus.load)
                shown_nxt = bus.value;
            else if (pending)
                shown_nxt = pending_val;
        end
    end

    always_comb begin
        nib = shown_nxt[{idx_nxt, 2'b00} +: 4];
        case (idx_nxt)
            2'd3:    blank = (shown_nxt[15:12] == 4'h0);
            2'd2:    blank = (shown_nxt[15:8]  == 8'h00);
            2'd1:    blank = (shown_nxt[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
        if (BLANK_LZ == 0)
            blank = 1'b0;
        a_nxt = 4'b1111;
        c_nxt = 7'h7F;
        if (state_nxt == S_SCAN && cnt_nxt >= GUARD_C) begin
            a_nxt = ~(4'b0001 << idx_nxt);
            c_nxt = blank ? 7'h7F : seg7(nib);
        end
    end

    assign bus.ack        = ack_r;
    assign bus.frame_tick = frame_tick_r;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - scoreboard bench for ssd_scan_driver (REFRESH_DIV=8, GUARD=2)
module tb_ssd_scan_driver;
    localparam int DIV = 8;
    localparam int GRD = 2;

    logic       real_clk = 1'b0;
    logic       reset    = 1'b1;
    logic [3:0] A;
    logic [6:0] C;

    ssd_scan_driver_if bus();

    ssd_scan_driver #(.REFRESH_DIV(DIV), .GUARD(GRD), .BLANK_LZ(1)) dut (
        .real_clk (real_clk),
        .reset    (reset),
        .bus      (bus),
        .A        (A),
        .C        (C)
    );

    always #5 real_clk = ~real_clk;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] cur_shown = 16'h0000;

    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        case (d)
            4'h0: exp_seg = 7'b0000001;  4'h1: exp_seg = 7'b1001111;
            4'h2: exp_seg = 7'b0010010;  4'h3: exp_seg = 7'b0000110;
            4'h4: exp_seg = 7'b1001100;  4'h5: exp_seg = 7'b0100100;
            4'h6: exp_seg = 7'b0100000;  4'h7: exp_seg = 7'b0001111;
            4'h8: exp_seg = 7'b0000000;  4'h9: exp_seg = 7'b0000100;
            4'hA: exp_seg = 7'b0001000;  4'hB: exp_seg = 7'b1100000;
            4'hC: exp_seg = 7'b0110001;  4'hD: exp_seg = 7'b1000010;
            4'hE: exp_seg = 7'b0110000;  default: exp_seg = 7'b0111000;
        endcase
    endfunction

    function automatic logic [3:0] exp_anode(input int s);
        case (s)
            3: exp_anode = 4'b0111;
            2: exp_anode = 4'b1011;
            1: exp_anode = 4'b1101;
            default: exp_anode = 4'b1110;
        endcase
    endfunction

    function automatic logic [6:0] exp_digit(input logic [15:0] v, input int s);
        logic [15:0] hi;
        hi = v >> (4 * s);
        if (s > 0 && hi == 16'h0000)
            exp_digit = 7'h7F;
        else
            exp_digit = exp_seg(hi[3:0]);
    endfunction

    // Starts at the negedge right after a boundary; ends at the next such negedge.
    task automatic check_frame(input logic [15:0] v, input int c1, input logic [15:0] v1,
                               input int c2, input logic [15:0] v2);
        int          i;
        logic [3:0]  ea;
        logic [6:0]  ec;
        for (int s = 3; s >= 0; s--) begin
            for (int n = 0; n < DIV; n++) begin
                i  = (3 - s) * DIV + n;
                ea = (n < GRD) ? 4'b1111 : exp_anode(s);
                ec = (n < GRD) ? 7'h7F : exp_digit(v, s);
                checks++;
                if (A !== ea) begin
                    errors++;
                    $display("FAIL anode shown=%h slot=%0d cnt=%0d: got %b want %b", v, s, n, A, ea);
                end
                checks++;
                if (C !== ec) begin
                    errors++;
                    $display("FAIL seg shown=%h slot=%0d cnt=%0d: got %b want %b", v, s, n, C, ec);
                end
                if (i != 0) begin
                    checks++;
                    if ({bus.ack, bus.frame_tick} !== 2'b00) begin
                        errors++;
                        $display("FAIL midframe_pulse i=%0d: got ack/ft=%b want 00", i, {bus.ack, bus.frame_tick});
                    end
                end
                if (i == c1) begin
                    bus.load = 1'b1; bus.value = v1; exp_q.push_back(v1);
                end else if (i == c2) begin
                    bus.load = 1'b1; bus.value = v2;
                    if (exp_q.size() > 0) void'(exp_q.pop_back());
                    exp_q.push_back(v2);
                end else begin
                    bus.load = 1'b0;
                end
                @(negedge real_clk);
            end
        end
        bus.load = 1'b0;
        checks++;
        if (bus.frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL frame_tick at boundary: got %b want 1", bus.frame_tick);
        end
    endtask

    task automatic run_frame(input int c1, input logic [15:0] v1, input int c2, input logic [15:0] v2);
        checks++;
        if (exp_q.size() > 0) begin
            cur_shown = exp_q.pop_front();
            if (bus.ack !== 1'b1) begin
                errors++;
                $display("FAIL ack for %h: got %b want 1", cur_shown, bus.ack);
            end
        end else if (bus.ack !== 1'b0) begin
            errors++;
            $display("FAIL spurious ack: got %b want 0", bus.ack);
        end
        check_frame(cur_shown, c1, v1, c2, v2);
    endtask

    task automatic do_reset;
        bus.load = 1'b0;
        reset    = 1'b1;
        repeat (2) @(negedge real_clk);
        checks++;
        if ({A, C, bus.ack, bus.frame_tick} !== {4'b1111, 7'h7F, 2'b00}) begin
            errors++;
            $display("FAIL reset_state: got A=%b C=%b ack=%b ft=%b want 1111 1111111 0 0", A, C, bus.ack, bus.frame_tick);
        end
        reset = 1'b0;
        exp_q.delete();
        cur_shown = 16'h0000;
        for (int k = 1; k <= DIV; k++) begin
            @(negedge real_clk);
            checks++;
            if ({A, C} !== {4'b1111, 7'h7F}) begin
                errors++;
                $display("FAIL init_blank k=%0d: got A=%b C=%b want 1111 1111111", k, A, C);
            end
            checks++;
            if ({bus.ack, bus.frame_tick} !== ((k == DIV) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL init_pulses k=%0d: got ack/ft=%b want %b", k, {bus.ack, bus.frame_tick},
                         (k == DIV) ? 2'b01 : 2'b00);
            end
        end
    endtask

    task automatic test_reset;
        do_reset();
        run_frame(-1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_load_midframe;
        run_frame(9, 16'h12AF, -1, 16'h0);
        run_frame(-1, 16'h0, -1, 16'h0);
        run_frame(-1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_last_wins;
        run_frame(3, 16'h1111, 17, 16'h2222);
        run_frame(-1, 16'h0, -1, 16'h0);
        run_frame(-1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_boundary_load;
        run_frame(4 * DIV - 1, 16'h0040, -1, 16'h0);
        run_frame(-1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_back_to_back;
        run_frame(4 * DIV - 1, 16'hABCD, -1, 16'h0);
        run_frame(4 * DIV - 1, 16'h0005, -1, 16'h0);
        run_frame(-1, 16'h0, -1, 16'h0);
        run_frame(-1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_reset_abort;
        bus.load  = 1'b1;
        bus.value = 16'hFFFF;
        @(negedge real_clk);
        bus.load = 1'b0;
        repeat (9) @(negedge real_clk);
        do_reset();
        run_frame(-1, 16'h0, -1, 16'h0);
        run_frame(-1, 16'h0, -1, 16'h0);
    endtask

    initial begin
        bus.load  = 1'b0;
        bus.value = 16'h0000;
        test_reset();
        test_load_midframe();
        test_last_wins();
        test_boundary_load();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
